mult_share_arbiter: RTL and testbench

Shares the single pipelined 32x32->32 (low word) multiplier cell between NUM_REQ requesters, such as the CPU custom-instruction port and a DSP accelerator.
- Round-robin arbitration over per-requester valid/ready request handshakes.
- Registers the granted operands into the cell.
- Tracks in-flight request IDs through a tag pipeline matched to the cell latency.
- Returns each product to its originating requester as a one-cycle response pulse.

---
 rtl/mult_arb_pkg.sv | 24 ++
 rtl/mult_arb_rr_picker.sv | 16 +
 rtl/mult_share_arbiter.sv | 85 ++++++++
 tb/tb_mult_share_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared types, constants and the round-robin pick function for the multiplier arbiter.
package mult_arb_pkg;
    localparam int OPW  = 32;
    localparam int ID_W = 3;
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;
    typedef struct packed {
        logic            any;
        logic [ID_W-1:0] idx;
    } pick_t;
    // Descending scan so the lowest circular distance from ptr wins.
    function automatic pick_t rr_pick(input logic [7:0] valid, input logic [ID_W-1:0] ptr, input int n);
        pick_t           p;
        logic [ID_W-1:0] j;
        p = '0;
        for (int k = n - 1; k >= 0; k--) begin
            j = ID_W'((int'(ptr) + k) % n);
            if (valid[j]) p = '{any: 1'b1, idx: j};
        end
        return p;
    endfunction
endpackage

// File: rtl/mult_arb_rr_picker.sv
// mult_arb_rr_picker: combinational circular priority select starting at ptr.
module mult_arb_rr_picker
    import mult_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]    valid,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] grant,
    output logic            any
);
    pick_t p;
    always_comb p = rr_pick(8'(valid), ptr, N);
    assign grant = p.idx;
    assign any   = p.any;
endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one pipelined 32x32 multiplier cell between requesters.
// Optional per-requester grant counters under MULT_ARB_STATS_EN.
module mult_share_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int MUL_LATENCY = 1,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*OPW-1:0] req_src1,
    input  logic [NUM_REQ*OPW-1:0] req_src2,
    output logic [OPW-1:0]         mul_src1,
    output logic [OPW-1:0]         mul_src2,
    input  logic [OPW-1:0]         mul_result,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [OPW-1:0]         rsp_result,
    output logic                   busy,
    input  logic [2:0]             stat_sel,
    input  logic                   stat_clr,
    output logic [CNT_W-1:0]       stat_count
);
    localparam int D = MUL_LATENCY + 1;
    logic [ID_W-1:0] rr_ptr, grant;
    logic            any, transfer;
    tag_t            tags [D];

    mult_arb_rr_picker #(.N(NUM_REQ)) u_pick (
        .valid(req_valid),
        .ptr  (rr_ptr),
        .grant(grant),
        .any  (any)
    );

    assign transfer  = any && !reset;
    assign req_ready = transfer ? NUM_REQ'(1) << grant : '0;

    // Tag stage D-1 lines up with the cell result for the same request.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr     <= '0;
            mul_src1   <= '0;
            mul_src2   <= '0;
            rsp_valid  <= '0;
            rsp_result <= '0;
            for (int i = 0; i < D; i++) tags[i] <= '0;
        end else begin
            tags[0] <= '{valid: transfer, id: grant};
            for (int i = 1; i < D; i++) tags[i] <= tags[i-1];
            if (transfer) begin
                rr_ptr   <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
                mul_src1 <= req_src1[grant*OPW +: OPW];
                mul_src2 <= req_src2[grant*OPW +: OPW];
            end
            rsp_valid <= tags[D-1].valid ? NUM_REQ'(1) << tags[D-1].id : '0;
            if (tags[D-1].valid) rsp_result <= mul_result;
        end
    end

    always_comb begin
        busy = |rsp_valid;
        for (int i = 0; i < D; i++) busy = busy | tags[i].valid;
    end

`ifdef MULT_ARB_STATS_EN
    logic [CNT_W-1:0] cnt [NUM_REQ];
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (reset || stat_clr) cnt[i] <= '0;
            else if (transfer && grant == ID_W'(i) && !(&cnt[i])) cnt[i] <= cnt[i] + 1'b1;
        end
    end
    always_comb begin
        stat_count = '0;
        for (int i = 0; i < NUM_REQ; i++) if (stat_sel == 3'(i)) stat_count = cnt[i];
    end
`else
    logic unused_stat;
    assign unused_stat = ^{stat_sel, stat_clr};
    assign stat_count  = '0;
`endif
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed self-checking bench with a one-stage multiplier cell model.
module tb_mult_share_arbiter;
`ifdef MULT_ARB_STATS_EN
    localparam int CW = 3;
`else
    localparam int CW = 16;
`endif
    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [63:0]   req_src1, req_src2;
    logic [31:0]   mul_src1, mul_src2, mul_result, rsp_result;
    logic [1:0]    rsp_valid;
    logic          busy;
    logic [2:0]    stat_sel;
    logic          stat_clr;
    logic [CW-1:0] stat_count;
    logic [31:0]   cell_q;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) cell_q <= mul_src1 * mul_src2;
    assign mul_result = cell_q;

    mult_share_arbiter #(.NUM_REQ(2), .MUL_LATENCY(1), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_src1  (req_src1),
        .req_src2  (req_src2),
        .mul_src1  (mul_src1),
        .mul_src2  (mul_src2),
        .mul_result(mul_result),
        .rsp_valid (rsp_valid),
        .rsp_result(rsp_result),
        .busy      (busy),
        .stat_sel  (stat_sel),
        .stat_clr  (stat_clr),
        .stat_count(stat_count)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_src1  = '0;
        req_src2  = '0;
        stat_sel  = '0;
        stat_clr  = 1'b0;
        tick();
        tick();
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_mul_src1", mul_src1, 0);
        check("rst_mul_src2", mul_src2, 0);
        req_valid = 2'b01;
        #1;
        check("rst_ready_gated", 32'(req_ready), 0);
        reset = 1'b0;
        req_src1[31:0] = 7;
        req_src2[31:0] = 6;
        #1;
        check("single_ready", 32'(req_ready), 32'b01);
        tick();
        req_valid = '0;
        check("single_busy", 32'(busy), 1);
        check("single_mul_src1", mul_src1, 7);
        tick();
        check("single_no_rsp_early", 32'(rsp_valid), 0);
        tick();
        check("single_rsp_valid", 32'(rsp_valid), 32'b01);
        check("single_rsp_result", rsp_result, 42);
        tick();
        check("single_rsp_pulse", 32'(rsp_valid), 0);
        check("single_rsp_hold", rsp_result, 42);

        // rr_ptr is now 1; requester 1 issues back to back
        req_valid = 2'b10;
        req_src1[63:32] = 32'hFFFF_FFFF;
        req_src2[63:32] = 2;
        #1;
        check("b2b_ready0", 32'(req_ready), 32'b10);
        tick();
        req_src1[63:32] = 1234;
        req_src2[63:32] = 1000;
        #1;
        check("b2b_ready1", 32'(req_ready), 32'b10);
        tick();
        req_valid = '0;
        tick();
        check("b2b_rsp0_valid", 32'(rsp_valid), 32'b10);
        check("b2b_rsp0_result", rsp_result, 32'hFFFF_FFFE);
        tick();
        check("b2b_rsp1_valid", 32'(rsp_valid), 32'b10);
        check("b2b_rsp1_result", rsp_result, 1234000);
        tick();
        check("b2b_rsp_end", 32'(rsp_valid), 0);

        // contention from rr_ptr=0
        req_valid = 2'b11;
        req_src1 = {32'd3, 32'h0001_0000};
        req_src2 = {32'd5, 32'h0001_0000};
        for (int c = 0; c < 8; c++) begin
            if (c == 4) req_valid = '0;
            #1;
            if (c < 4) check($sformatf("cont_ready%0d", c), 32'(req_ready), (c % 2 == 0) ? 32'b01 : 32'b10);
            if (c >= 3 && c <= 6) begin
                check($sformatf("cont_rsp_valid%0d", c), 32'(rsp_valid), ((c - 3) % 2 == 0) ? 32'b01 : 32'b10);
                check($sformatf("cont_rsp_result%0d", c), rsp_result, ((c - 3) % 2 == 0) ? 32'd0 : 32'd15);
            end
            if (c == 7) check("cont_rsp_end", 32'(rsp_valid), 0);
            tick();
        end

        // reset one cycle after issue drops the in-flight request
        req_valid = 2'b01;
        req_src1[31:0] = 9;
        req_src2[31:0] = 9;
        tick();
        reset = 1'b1;
        req_valid = 2'b10;
        #1;
        check("midrst_ready_gated", 32'(req_ready), 0);
        tick();
        reset = 1'b0;
        req_valid = '0;
        check("midrst_busy", 32'(busy), 0);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("midrst_no_rsp%0d", c), 32'(rsp_valid), 0);
            tick();
        end
        req_valid = 2'b11;
        req_src1 = {32'd77, 32'd2};
        req_src2 = {32'd77, 32'd2};
        #1;
        check("midrst_ptr_zero", 32'(req_ready), 32'b01);
        tick();
        req_valid = '0;
        tick();
        tick();
        check("midrst_rsp_valid", 32'(rsp_valid), 32'b01);
        check("midrst_rsp_result", rsp_result, 4);
        tick();

        // idle: operands change on the inputs but the cell inputs hold
        req_src1 = {32'hDEAD_BEEF, 32'h1234_5678};
        req_src2 = {32'hCAFE_F00D, 32'h0BAD_F00D};
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("idle_src1_%0d", c), mul_src1, 2);
            check($sformatf("idle_src2_%0d", c), mul_src2, 2);
            check($sformatf("idle_rsp%0d", c), 32'(rsp_valid), 0);
            check($sformatf("idle_busy%0d", c), 32'(busy), 0);
        end

`ifdef MULT_ARB_STATS_EN
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        req_valid = 2'b01;
        for (int c = 0; c < 5; c++) tick();
        req_valid = '0;
        stat_sel = 3'd0;
        #1;
        check("stat_req0_five", 32'(stat_count), 5);
        stat_sel = 3'd1;
        #1;
        check("stat_req1_zero", 32'(stat_count), 0);
        stat_sel = 3'd7;
        #1;
        check("stat_sel_oob", 32'(stat_count), 0);
        stat_sel = 3'd0;
        stat_clr = 1'b1;
        req_valid = 2'b01;
        tick();
        stat_clr = 1'b0;
        req_valid = '0;
        check("stat_clr_priority", 32'(stat_count), 0);
        req_valid = 2'b01;
        for (int c = 0; c < 8; c++) tick();
        req_valid = '0;
        check("stat_saturate", 32'(stat_count), 7);
`else
        req_valid = 2'b01;
        for (int c = 0; c < 3; c++) tick();
        req_valid = '0;
        stat_sel = 3'd0;
        #1;
        check("stat_tied_zero", 32'(stat_count), 0);
`endif
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
